// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester and transmitter signals around the shared UART TX arbiter
interface uart_tx_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8,
  parameter int ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1
);
  logic [N_REQ-1:0]        req;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic                    t_done;
  logic [N_REQ-1:0]        grant;
  logic                    tx_start;
  logic [DATA_W-1:0]       tx_data;
  logic [ID_W-1:0]         active_id;
  logic                    busy;
  logic                    timeout_err;

  // Requesters and the transmitter core together form the master side.
  modport master (
    output req,
    output req_data,
    output t_done,
    input  grant,
    input  tx_start,
    input  tx_data,
    input  active_id,
    input  busy,
    input  timeout_err
  );

  // The arbiter itself.
  modport slave (
    input  req,
    input  req_data,
    input  t_done,
    output grant,
    output tx_start,
    output tx_data,
    output active_id,
    output busy,
    output timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin sharing of one UART transmitter with a frame watchdog
module uart_tx_arbiter #(
  parameter int N_REQ       = 4,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic             clk,
  input  logic             rst,
  uart_tx_arbiter_if.slave bus
);
  localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

  localparam logic             WDOG_EN  = (TIMEOUT_CYC != 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(TIMEOUT_CYC - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  // Pointer reset value: last requester, so the search starts at requester 0.
  localparam logic [ID_W-1:0] PTR_RST = ID_W'(N_REQ - 1);

  logic [1:0]        state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic              tx_start_q, tx_start_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic [ID_W-1:0]   active_id_q, active_id_d;
  logic              busy_q, busy_d;
  logic              timeout_err_q, timeout_err_d;

  // Winner search: one extra bit so ptr+k can exceed N_REQ before wrapping.
  logic              win_found;
  logic [ID_W-1:0]   win_idx;
  logic [ID_W:0]     cand;
  logic [DATA_W-1:0] win_data;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = {1'b0, ptr_q} + (ID_W + 1)'(k);
      if (cand >= (ID_W + 1)'(N_REQ)) begin
        cand = cand - (ID_W + 1)'(N_REQ);
      end
      if (!win_found && bus.req[cand[ID_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[ID_W-1:0];
      end
    end
  end

  // Byte of the winning requester, latched on the grant.
  always_comb begin
    win_data = bus.req_data[int'(win_idx) * DATA_W +: DATA_W];
  end

  // Next-state logic for the IDLE -> SEND -> GAP frame sequence.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    cnt_d         = cnt_q;
    grant_d       = '0;
    tx_start_d    = tx_start_q;
    tx_data_d     = tx_data_q;
    active_id_d   = active_id_q;
    busy_d        = busy_q;
    timeout_err_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d          = S_SEND;
          grant_d[win_idx] = 1'b1;
          tx_data_d        = win_data;
          active_id_d      = win_idx;
          ptr_d            = win_idx;
          tx_start_d       = 1'b1;
          busy_d           = 1'b1;
          cnt_d            = '0;
        end
      end

      S_SEND: begin
        if (WDOG_EN && (cnt_q != CNT_MAX)) begin
          cnt_d = cnt_q + 1'b1;
        end
        // A completion on the terminal count still counts as a clean frame.
        if (bus.t_done) begin
          state_d    = S_GAP;
          tx_start_d = 1'b0;
        end else if (WDOG_EN && (cnt_q == CNT_TERM)) begin
          state_d       = S_GAP;
          tx_start_d    = 1'b0;
          timeout_err_d = 1'b1;
        end
      end

      S_GAP: begin
        // One low cycle on tx_start so the transmitter sees a falling edge.
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d    = S_IDLE;
        tx_start_d = 1'b0;
        busy_d     = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops tx_start and busy immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      ptr_q         <= PTR_RST;
      cnt_q         <= '0;
      grant_q       <= '0;
      tx_start_q    <= 1'b0;
      tx_data_q     <= '0;
      active_id_q   <= '0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      cnt_q         <= cnt_d;
      grant_q       <= grant_d;
      tx_start_q    <= tx_start_d;
      tx_data_q     <= tx_data_d;
      active_id_q   <= active_id_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.tx_start    = tx_start_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.active_id   = active_id_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed and randomized checks of uart_tx_arbiter against a frame-level model
module tb_uart_tx_arbiter;
  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;

  int vectors     = 0;
  int miscompares = 0;
  int ptr_a       = 3;

  uart_tx_arbiter_if #(.N_REQ(4), .DATA_W(8)) if_a ();
  uart_tx_arbiter_if #(.N_REQ(4), .DATA_W(8)) if_b ();

  uart_tx_arbiter #(.N_REQ(4), .DATA_W(8), .TIMEOUT_CYC(64)) u_dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (if_a.slave)
  );

  uart_tx_arbiter #(.N_REQ(4), .DATA_W(8), .TIMEOUT_CYC(8)) u_dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (if_b.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Round-robin rule: first requesting index after the last winner, wrapping.
  function automatic int rr_pick(input int ptr, input logic [3:0] r);
    for (int k = 1; k <= 4; k++) begin
      if (r[(ptr + k) % 4]) return (ptr + k) % 4;
    end
    return -1;
  endfunction

  // One complete frame on instance A: grant, flen cycles of tx_start, GAP, IDLE.
  task automatic frame_a(input logic [3:0] r, input logic [31:0] d, input int flen, output int w);
    logic [7:0] byte_exp;
    w = rr_pick(ptr_a, r);
    byte_exp = d[w*8 +: 8];
    if_a.req = r;
    if_a.req_data = d;
    tick();
    chk("grant", if_a.grant, 32'(1) << w);
    chk("tx_start_rise", if_a.tx_start, 1);
    chk("tx_data", if_a.tx_data, byte_exp);
    chk("active_id", if_a.active_id, w);
    chk("busy_send", if_a.busy, 1);
    ptr_a = w;
    for (int i = 1; i < flen; i++) begin
      if (i == 1) if_a.req = 4'($urandom);
      tick();
      chk("grant_pulse", if_a.grant, 0);
      chk("tx_start_hold", if_a.tx_start, 1);
      chk("tx_data_frozen", if_a.tx_data, byte_exp);
    end
    if_a.t_done = 1'b1;
    tick();
    if_a.t_done = 1'b0;
    chk("gap_tx_start", if_a.tx_start, 0);
    chk("gap_busy", if_a.busy, 1);
    chk("gap_timeout_err", if_a.timeout_err, 0);
    tick();
    chk("idle_busy", if_a.busy, 0);
    chk("idle_tx_start", if_a.tx_start, 0);
    chk("idle_active_id", if_a.active_id, w);
    if_a.req = '0;
  endtask

  initial begin
    int w;
    int rr_exp[6] = '{0, 1, 2, 3, 0, 1};
    logic [3:0] r;

    if_a.req = '0; if_a.req_data = '0; if_a.t_done = 1'b0;
    if_b.req = '0; if_b.req_data = '0; if_b.t_done = 1'b0;

    // Reset held for three cycles, outputs all zero.
    for (int i = 0; i < 3; i++) tick();
    chk("rst_grant", if_a.grant, 0);
    chk("rst_tx_start", if_a.tx_start, 0);
    chk("rst_tx_data", if_a.tx_data, 0);
    chk("rst_active_id", if_a.active_id, 0);
    chk("rst_busy", if_a.busy, 0);
    chk("rst_timeout_err", if_a.timeout_err, 0);
    rst_a = 1'b0;
    rst_b = 1'b0;
    tick();
    if_a.t_done = 1'b1;
    tick();
    if_a.t_done = 1'b0;
    tick();
    chk("idle_tdone_busy", if_a.busy, 0);
    chk("idle_tdone_start", if_a.tx_start, 0);
    chk("idle_tdone_grant", if_a.grant, 0);

    // Single request from requester 2, ten-cycle frame.
    frame_a(4'b0100, 32'h00A5_0000, 10, w);

    // Round-robin from a fresh reset with all requesters held.
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    ptr_a = 3;
    for (int i = 0; i < 6; i++) begin
      frame_a(4'b1111, 32'h4433_2211 + 32'(i), 5, w);
      chk("rr_order", 32'(w), rr_exp[i]);
    end

    // Randomized traffic.
    for (int i = 0; i < 24; i++) begin
      r = 4'($urandom_range(1, 15));
      frame_a(r, $urandom, $urandom_range(1, 12), w);
    end

    // Watchdog: no t_done, frame aborted after exactly 8 cycles.
    if_b.req = 4'b0011;
    if_b.req_data = 32'h4433_2211;
    tick();
    chk("to_grant", if_b.grant, 4'b0001);
    chk("to_tx_data", if_b.tx_data, 8'h11);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk("to_tx_start_hold", if_b.tx_start, 1);
      chk("to_no_err_yet", if_b.timeout_err, 0);
    end
    tick();
    chk("to_tx_start_drop", if_b.tx_start, 0);
    chk("to_err_pulse", if_b.timeout_err, 1);
    chk("to_gap_busy", if_b.busy, 1);
    tick();
    chk("to_err_clear", if_b.timeout_err, 0);
    chk("to_idle_busy", if_b.busy, 0);
    tick();
    chk("to_next_grant", if_b.grant, 4'b0010);
    chk("to_next_data", if_b.tx_data, 8'h22);

    // t_done on the terminal watchdog cycle: clean completion.
    for (int i = 1; i < 8; i++) begin
      tick();
      chk("sim_tx_start_hold", if_b.tx_start, 1);
    end
    if_b.t_done = 1'b1;
    if_b.req = '0;
    tick();
    if_b.t_done = 1'b0;
    chk("sim_tx_start_drop", if_b.tx_start, 0);
    chk("sim_no_err", if_b.timeout_err, 0);
    tick();
    chk("sim_no_err_late", if_b.timeout_err, 0);
    chk("sim_idle_busy", if_b.busy, 0);

    // Reset in cycle 4 of a frame from requester 2.
    if_b.req = 4'b0100;
    tick();
    chk("mr_grant", if_b.grant, 4'b0100);
    for (int i = 0; i < 3; i++) tick();
    chk("mr_tx_start_before", if_b.tx_start, 1);
    rst_b = 1'b1;
    #1;
    chk("mr_tx_start_async", if_b.tx_start, 0);
    chk("mr_busy_async", if_b.busy, 0);
    chk("mr_active_id", if_b.active_id, 0);
    if_b.req = 4'b1001;
    tick();
    rst_b = 1'b0;
    chk("mr_idle", if_b.busy, 0);
    tick();
    chk("mr_next_grant", if_b.grant, 4'b0001);
    if_b.req = '0;
    if_b.t_done = 1'b1;
    tick();
    if_b.t_done = 1'b0;
    chk("mr_gap", if_b.busy, 1);
    tick();
    chk("mr_end_idle", if_b.busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
